// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES streaming front end.
package aes_pkg;

    localparam int   AES_BLK_W = 128;
    localparam logic MODE_ENC  = 1'b0;
    localparam logic MODE_DEC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        EMIT
    } aes_state_e;

endpackage

// File: rtl/aes_beat_shift.sv
// Beat-wide shift register used both to assemble a 128-bit word from host
// beats and to serialise a 128-bit result back into beats. Carries its own
// beat counter so the owner only decides when to clear or restart it.
module aes_beat_shift
    import aes_pkg::*;
#(
    parameter  int BUS_W = 32,
    localparam int BEATS = AES_BLK_W / BUS_W,
    localparam int CNT_W = $clog2(BEATS + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [AES_BLK_W-1:0] i_load_val,
    input  logic                 i_shift,
    input  logic [BUS_W-1:0]     i_din,
    input  logic                 i_cnt_clr,
    input  logic                 i_cnt_set1,
    output logic [AES_BLK_W-1:0] o_q,
    output logic [CNT_W-1:0]     o_cnt
);

    logic [AES_BLK_W-1:0] r_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [AES_BLK_W-1:0] w_shifted;

    // Keeping the low 128 bits of the concatenation makes BUS_W=128 a plain load.
    assign w_shifted = AES_BLK_W'({r_q, i_din});

    // Word register and beat counter; a parallel load also restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_q   <= i_load_val;
            r_cnt <= '0;
        end else begin
            if (i_shift)
                r_q <= w_shifted;
            if (i_cnt_clr)
                r_cnt <= '0;
            else if (i_cnt_set1)
                r_cnt <= CNT_W'(1);
            else if (i_shift)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_q   = r_q;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/aes_stream_io.sv
// Word-serial valid/ready front end for the AES-128 cores: assembles key and
// block beats, starts the core, and streams the 128-bit result back out.
//
//   state | meaning
//   IDLE  | accepting key/block beats
//   START | one-cycle core_start pulse
//   WAIT  | waiting for core_done, bounded by TIMEOUT
//   EMIT  | returning result beats, MSB beat first
module aes_stream_io
    import aes_pkg::*;
#(
    parameter int BUS_W   = 32,
    parameter int TIMEOUT = 64
)(
    input  logic                 Clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_W-1:0]     in_data,
    input  logic                 in_is_key,
    input  logic                 mode_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_W-1:0]     out_data,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_block,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_result,
    output logic                 key_loaded,
    output logic                 busy,
    output logic                 err
);

    localparam int BEATS = AES_BLK_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    aes_state_e r_state, w_state_nxt;

    logic                 r_in_ready, r_kind, r_key_loaded, r_err, r_core_mode;
    logic [AES_BLK_W-1:0] r_core_key, r_core_block;
    logic [TMR_W-1:0]     r_tmr;

    logic [AES_BLK_W-1:0] w_in_q, w_in_full, w_out_q;
    logic [CNT_W-1:0]     w_in_cnt, w_out_cnt;
    logic w_in_acc, w_mismatch, w_in_last, w_in_clr, w_in_set1;
    logic w_key_done, w_blk_done, w_blk_drop;
    logic w_res_load, w_out_hs, w_out_last, w_timeout;
    logic w_core_start, w_out_valid, w_busy;

    assign w_in_acc   = in_valid & r_in_ready & (r_state == IDLE);
    // A kind switch mid-word discards the partial word; the current beat becomes beat 1.
    assign w_mismatch = (w_in_cnt != '0) && (in_is_key != r_kind);
    assign w_in_last  = !w_mismatch && (w_in_cnt == LAST_BEAT);
    assign w_in_clr   = w_in_acc & w_in_last;
    assign w_in_set1  = w_in_acc & w_mismatch;
    assign w_in_full  = AES_BLK_W'({w_in_q, in_data});

    assign w_key_done = w_in_clr & in_is_key;
    assign w_blk_done = w_in_clr & ~in_is_key & r_key_loaded;
    assign w_blk_drop = w_in_clr & ~in_is_key & ~r_key_loaded;

    assign w_res_load = (r_state == WAIT) & core_done;
    assign w_timeout  = (r_state == WAIT) & ~core_done & (r_tmr == TMR_W'(1));
    assign w_out_hs   = (r_state == EMIT) & out_ready;
    assign w_out_last = w_out_hs & (w_out_cnt == LAST_BEAT);

    aes_beat_shift #(.BUS_W(BUS_W)) u_in_shift (
        .clk        (Clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_shift    (w_in_acc),
        .i_din      (in_data),
        .i_cnt_clr  (w_in_clr),
        .i_cnt_set1 (w_in_set1),
        .o_q        (w_in_q),
        .o_cnt      (w_in_cnt)
    );

    aes_beat_shift #(.BUS_W(BUS_W)) u_out_shift (
        .clk        (Clk),
        .rst        (rst),
        .i_load     (w_res_load),
        .i_load_val (core_result),
        .i_shift    (w_out_hs),
        .i_din      ('0),
        .i_cnt_clr  (w_out_last),
        .i_cnt_set1 (1'b0),
        .o_q        (w_out_q),
        .o_cnt      (w_out_cnt)
    );

    // State register.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_core_start = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_blk_done)
                    w_state_nxt = START;
            end
            START: begin
                w_core_start = 1'b1;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done)
                    w_state_nxt = EMIT;
                else if (w_timeout)
                    w_state_nxt = IDLE;
            end
            EMIT: begin
                w_out_valid = 1'b1;
                if (w_out_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Key/block capture, handshake ready, watchdog timer and sticky error.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_in_ready   <= 1'b0;
            r_kind       <= 1'b0;
            r_key_loaded <= 1'b0;
            r_err        <= 1'b0;
            r_core_mode  <= MODE_ENC;
            r_core_key   <= '0;
            r_core_block <= '0;
            r_tmr        <= '0;
        end else begin
            // Registered from the next state so ready drops in START and rises the cycle after EMIT ends.
            r_in_ready <= (w_state_nxt == IDLE);
            if (w_in_acc)
                r_kind <= in_is_key;
            if (w_key_done) begin
                r_core_key   <= w_in_full;
                r_key_loaded <= 1'b1;
            end
            if (w_blk_done) begin
                r_core_block <= w_in_full;
                r_core_mode  <= mode_in;
            end
            if ((w_in_acc & w_mismatch) | w_blk_drop | w_timeout)
                r_err <= 1'b1;
            if (r_state == START)
                r_tmr <= TMR_W'(TIMEOUT - 1);
            else if (r_state == WAIT)
                r_tmr <= r_tmr - TMR_W'(1);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = BUS_W'(w_out_q >> (AES_BLK_W - BUS_W));
    assign core_start = w_core_start;
    assign core_mode  = r_core_mode;
    assign core_key   = r_core_key;
    assign core_block = r_core_block;
    assign key_loaded = r_key_loaded;
    assign busy       = w_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_aes_stream_io.sv
// Directed bench for aes_stream_io at BUS_W = 32, 8 and 128, with a small
// table-driven core model that knows the FIPS-197 appendix C.1 vector.
module tb_aes_stream_io;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_is_key = 1'b0, mode_in = 1'b0, out_ready = 1'b0;
    logic iv32 = 1'b0, iv8 = 1'b0, iv128 = 1'b0;
    logic [31:0]  id32  = '0;
    logic [7:0]   id8   = '0;
    logic [127:0] id128 = '0;
    logic ir32, ir8, ir128, ov32, ov8, ov128;
    logic [31:0]  od32;
    logic [7:0]   od8;
    logic [127:0] od128;
    logic cs32, cs8, cs128, cm32, cm8, cm128;
    logic [127:0] ck32, ck8, ck128, cb32, cb8, cb128, cr32, cr8, cr128;
    logic cd32, cd8, cd128, kl32, kl8, kl128, bz32, bz8, bz128, er32, er8, er128;

    logic [2:0] pipe32 = '0, pipe8 = '0, pipe128 = '0;
    bit model_en = 1'b1;
    int nstart32 = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_stream_io #(.BUS_W(32), .TIMEOUT(64)) dut32 (
        .Clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .in_is_key(in_is_key), .mode_in(mode_in), .out_valid(ov32), .out_ready(out_ready),
        .out_data(od32), .core_start(cs32), .core_mode(cm32), .core_key(ck32),
        .core_block(cb32), .core_done(cd32), .core_result(cr32), .key_loaded(kl32),
        .busy(bz32), .err(er32));

    aes_stream_io #(.BUS_W(8), .TIMEOUT(64)) dut8 (
        .Clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_is_key(in_is_key), .mode_in(mode_in), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .core_start(cs8), .core_mode(cm8), .core_key(ck8),
        .core_block(cb8), .core_done(cd8), .core_result(cr8), .key_loaded(kl8),
        .busy(bz8), .err(er8));

    aes_stream_io #(.BUS_W(128), .TIMEOUT(64)) dut128 (
        .Clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .in_data(id128),
        .in_is_key(in_is_key), .mode_in(mode_in), .out_valid(ov128), .out_ready(out_ready),
        .out_data(od128), .core_start(cs128), .core_mode(cm128), .core_key(ck128),
        .core_block(cb128), .core_done(cd128), .core_result(cr128), .key_loaded(kl128),
        .busy(bz128), .err(er128));

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] b,
                                               input logic m);
        if (k == KEY && b == PT && !m) return CT;
        if (k == KEY && b == CT && m)  return PT;
        return b ^ k ^ {128{m}};
    endfunction

    // Core model: done three cycles after start, result from the vector table.
    always @(posedge clk) begin
        pipe32  <= {pipe32[1:0],  cs32  & model_en};
        pipe8   <= {pipe8[1:0],   cs8   & model_en};
        pipe128 <= {pipe128[1:0], cs128 & model_en};
        if (cs32) nstart32 <= nstart32 + 1;
    end
    assign cd32  = pipe32[2];
    assign cd8   = pipe8[2];
    assign cd128 = pipe128[2];
    assign cr32  = aes_model(ck32,  cb32,  cm32);
    assign cr8   = aes_model(ck8,   cb8,   cm8);
    assign cr128 = aes_model(ck128, cb128, cm128);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    function automatic logic rdyf(input int w);
        case (w)
            8:       return ir8;
            32:      return ir32;
            default: return ir128;
        endcase
    endfunction

    function automatic logic ovf(input int w);
        case (w)
            8:       return ov8;
            32:      return ov32;
            default: return ov128;
        endcase
    endfunction

    function automatic logic [127:0] odata(input int w);
        case (w)
            8:       return {120'b0, od8};
            32:      return {96'b0, od32};
            default: return od128;
        endcase
    endfunction

    task automatic send_beat(input int w, input logic [127:0] beat, input logic key);
        int n;
        n = 0;
        @(negedge clk);
        in_is_key = key;
        case (w)
            8:       begin id8   = beat[7:0];  iv8   = 1'b1; end
            32:      begin id32  = beat[31:0]; iv32  = 1'b1; end
            default: begin id128 = beat;       iv128 = 1'b1; end
        endcase
        while (!rdyf(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("tx_ready", rdyf(w), 1'b1);
        @(posedge clk);
        #1;
        iv8 = 1'b0; iv32 = 1'b0; iv128 = 1'b0;
    endtask

    task automatic send_word(input int w, input logic [127:0] word, input logic key,
                             input logic mode);
        logic [127:0] t;
        mode_in = mode;
        for (int i = 0; i < 128 / w; i++) begin
            t = word << (w * i);
            send_beat(w, t >> (128 - w), key);
        end
    endtask

    task automatic recv_beats(input int w, input int nb, input bit stall,
                              output logic [127:0] got);
        int k;
        bit stable;
        logic [127:0] d0;
        got = '0;
        for (int i = 0; i < nb; i++) begin
            k = 0;
            @(negedge clk);
            while (!ovf(w) && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk1("rx_valid", ovf(w), 1'b1);
            d0 = odata(w);
            if (stall) begin
                stable = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (odata(w) !== d0 || !ovf(w) || rdyf(w)) stable = 1'b0;
                end
                chk1("bp_stable", stable, 1'b1);
            end
            got = (got << w) | d0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] got;
        int k, n0;
        bit saw_ov;

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk1("rst_in_ready", ir32, 1'b0);
        chk1("rst_out_valid", ov32, 1'b0);
        chk("rst_out_data", 128'(od32), 128'd0);
        chk1("rst_core_start", cs32, 1'b0);
        chk1("rst_core_mode", cm32, 1'b0);
        chk("rst_core_key", ck32, 128'd0);
        chk("rst_core_block", cb32, 128'd0);
        chk1("rst_key_loaded", kl32, 1'b0);
        chk1("rst_busy", bz32, 1'b0);
        chk1("rst_err", er32, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("ready_after_rst", ir32, 1'b1);

        // FIPS-197 encrypt at BUS_W=32
        send_word(32, KEY, 1'b1, 1'b0);
        @(negedge clk);
        chk1("key_loaded", kl32, 1'b1);
        chk("core_key", ck32, KEY);
        send_word(32, PT, 1'b0, 1'b0);
        @(negedge clk);
        chk1("start_latency", cs32, 1'b1);
        chk1("start_in_ready", ir32, 1'b0);
        chk1("start_busy", bz32, 1'b1);
        chk("core_block", cb32, PT);
        chk1("core_mode_enc", cm32, 1'b0);
        k = 0;
        while (!ov32 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("done_to_valid", 128'(k), 128'd4);
        recv_beats(32, 4, 1'b0, got);
        chk("enc32", got, CT);
        chk1("enc32_err", er32, 1'b0);

        // Decrypt reusing the held key
        send_word(32, CT, 1'b0, 1'b1);
        @(negedge clk);
        chk1("core_mode_dec", cm32, 1'b1);
        recv_beats(32, 4, 1'b0, got);
        chk("dec32", got, PT);
        chk("start_count", 128'(nstart32), 128'd2);

        // Output backpressure
        send_word(32, PT, 1'b0, 1'b0);
        recv_beats(32, 4, 1'b1, got);
        chk("bp_data", got, CT);
        @(negedge clk);
        chk1("bp_ready_after", ir32, 1'b1);

        // Block before any key
        pulse_rst();
        n0 = nstart32;
        send_word(32, PT, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("nokey_starts", 128'(nstart32 - n0), 128'd0);
        chk1("nokey_err", er32, 1'b1);
        chk1("nokey_busy", bz32, 1'b0);

        // Two key beats then a data beat
        pulse_rst();
        send_beat(32, 128'h00010203, 1'b1);
        send_beat(32, 128'h04050607, 1'b1);
        send_beat(32, 128'h08090a0b, 1'b0);
        @(negedge clk);
        chk1("mix_err", er32, 1'b1);
        chk1("mix_key_loaded", kl32, 1'b0);

        // Core never answers
        pulse_rst();
        model_en = 1'b0;
        send_word(32, KEY, 1'b1, 1'b0);
        send_word(32, PT, 1'b0, 1'b0);
        @(negedge clk);
        chk1("to_start", cs32, 1'b1);
        k = 0;
        saw_ov = 1'b0;
        while (bz32 && k < 200) begin
            @(negedge clk);
            k++;
            if (ov32) saw_ov = 1'b1;
        end
        chk("to_cycles", 128'(k), 128'd64);
        chk1("to_no_output", saw_ov, 1'b0);
        chk1("to_err", er32, 1'b1);
        model_en = 1'b1;

        // Same vector at BUS_W=8 and BUS_W=128
        send_word(8, KEY, 1'b1, 1'b0);
        send_word(8, PT, 1'b0, 1'b0);
        recv_beats(8, 16, 1'b0, got);
        chk("enc8", got, CT);
        chk1("enc8_err", er8, 1'b0);
        send_word(128, KEY, 1'b1, 1'b0);
        send_word(128, PT, 1'b0, 1'b0);
        recv_beats(128, 1, 1'b0, got);
        chk("enc128", got, CT);
        send_word(128, CT, 1'b0, 1'b1);
        recv_beats(128, 1, 1'b1, got);
        chk("dec128_bp", got, PT);
        chk1("enc128_err", er128, 1'b0);

        // Reset in the middle of EMIT
        pulse_rst();
        send_word(32, KEY, 1'b1, 1'b0);
        send_word(32, PT, 1'b0, 1'b0);
        recv_beats(32, 2, 1'b0, got);
        chk("pre_rst_beats", got, 128'h69c4e0d86a7b0430);
        @(negedge clk);
        chk1("pre_rst_emit", ov32, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_out_valid", ov32, 1'b0);
        chk("mid_rst_out_data", 128'(od32), 128'd0);
        chk1("mid_rst_key_loaded", kl32, 1'b0);
        chk1("mid_rst_busy", bz32, 1'b0);
        chk("mid_rst_core_key", ck32, 128'd0);
        chk1("mid_rst_in_ready", ir32, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
